// File: rtl/serial_add_sequencer_pkg.sv
// ============================================================================
// Module      : serial_add_sequencer_pkg
// Description : State encodings shared by the bit-serial adder controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_add_sequencer_pkg;

    localparam int             c_STATE_W   = 2;
    localparam logic [1:0]     c_ST_IDLE   = 2'd0;
    localparam logic [1:0]     c_ST_RUN    = 2'd1;
    localparam logic [1:0]     c_ST_DONE   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/serial_add_sequencer_fa_cell.sv
// ============================================================================
// Module      : fa_cell
// Description : Structural 1-bit full adder, XOR/AND/XOR netlist.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    logic w_p;
    logic w_g;
    logic w_t;

    // Generate and propagate-with-carry are mutually exclusive, so XOR merges them.
    xor u_xp (w_p, i_a, i_b);
    xor u_xs (o_s, w_p, i_c);
    and u_ag (w_g, i_a, i_b);
    and u_at (w_t, w_p, i_c);
    xor u_xc (o_c, w_g, w_t);

endmodule

`default_nettype wire

// File: rtl/serial_add_sequencer.sv
// ============================================================================
// Module      : serial_add_sequencer
// Description : LSB-first bit-serial adder controller around one fa_cell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_sequencer
    import serial_add_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;
    logic [WIDTH-1:0]     r_a_sh;
    logic [WIDTH-1:0]     r_b_sh;
    logic [WIDTH-1:0]     r_sum;
    logic [c_CW-1:0]      r_count;
    logic                 r_carry;
    logic                 r_cout;
    logic                 r_ovf;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_s;
    logic                 w_c;

    assign w_accept = (r_state == c_ST_IDLE) && start;
    assign w_last   = (r_state == c_ST_RUN) && (r_count == c_LAST);

    fa_cell u_fa (
        .i_a (r_a_sh[0]),
        .i_b (r_b_sh[0]),
        .i_c (r_carry),
        .o_s (w_s),
        .o_c (w_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (start)  w_next_state = c_ST_RUN;
            c_ST_RUN:  if (w_last) w_next_state = c_ST_DONE;
            c_ST_DONE: w_next_state = c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (r_state)
            c_ST_IDLE: ready = 1'b1;
            c_ST_RUN:  busy  = 1'b1;
            c_ST_DONE: done  = 1'b1;
            default:   ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_count <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_sum   <= '0;
            r_count <= '0;
            r_carry <= cin;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == c_ST_RUN) begin
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_carry <= w_c;
            // On the MSB step the old carry is the carry into the MSB.
            if (w_last) begin
                r_cout <= w_c;
                r_ovf  <= r_carry ^ w_c;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_sequencer.sv
// ============================================================================
// Module      : tb_serial_add_sequencer
// Description : Self-checking bench for serial_add_sequencer against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_sequencer;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks;
    int failures;

    serial_add_sequencer #(.WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #250 clk = ~clk;

    // Reference: {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [WIDTH+1:0] ref_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic             c);
        int unsigned full;
        int          sx;
        int          sy;
        int          ss;
        logic        v;
        full = int'(x) + int'(y) + int'(c);
        sx   = x[WIDTH-1] ? int'(x) - (1 << WIDTH) : int'(x);
        sy   = y[WIDTH-1] ? int'(y) - (1 << WIDTH) : int'(y);
        ss   = sx + sy + int'(c);
        v    = (ss > (1 << (WIDTH-1)) - 1) || (ss < -(1 << (WIDTH-1)));
        return {v, full[WIDTH], full[WIDTH-1:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller sits #1 after an edge with the DUT in IDLE; returns #1 after the accepting edge.
    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic c, input logic keep);
        start = 1'b1;
        a     = x;
        b     = y;
        cin   = c;
        tick();
        start = keep;
        chk("accept_busy", {29'd0, ready, busy, done}, 32'b010);
    endtask

    // Runs the remaining RUN edges and checks the DONE cycle.
    task automatic finish_op(input string tag, input logic [WIDTH-1:0] x,
                             input logic [WIDTH-1:0] y, input logic c);
        logic [WIDTH+1:0] e;
        e = ref_add(x, y, c);
        for (int i = 1; i < WIDTH; i++) begin
            tick();
            chk({tag, "_run"}, {29'd0, ready, busy, done}, 32'b010);
        end
        tick();
        chk({tag, "_done"}, {29'd0, ready, busy, done}, 32'b001);
        chk({tag, "_sum"},  32'(sum),  32'(e[WIDTH-1:0]));
        chk({tag, "_cout"}, 32'(cout), 32'(e[WIDTH]));
        chk({tag, "_ovf"},  32'(ovf),  32'(e[WIDTH+1]));
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;
        logic             rk;
        logic [WIDTH+1:0] e;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;

        tick();
        tick();
        reset = 1'b0;
        chk("rst_flags", {29'd0, ready, busy, done}, 32'b100);
        chk("rst_sum",   32'(sum),  32'd0);
        chk("rst_cout",  32'(cout), 32'd0);
        chk("rst_ovf",   32'(ovf),  32'd0);

        issue(8'h5A, 8'h33, 1'b0, 1'b0);
        finish_op("op5a33", 8'h5A, 8'h33, 1'b0);
        chk("op5a33_lit", {22'd0, ovf, cout, sum}, {22'd0, 1'b1, 1'b0, 8'h8D});
        tick();
        chk("op5a33_idle", {29'd0, ready, busy, done}, 32'b100);

        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        finish_op("opff01", 8'hFF, 8'h01, 1'b0);
        chk("opff01_lit", {22'd0, ovf, cout, sum}, {22'd0, 1'b0, 1'b1, 8'h00});
        tick();

        issue(8'h80, 8'h80, 1'b1, 1'b0);
        finish_op("op8080", 8'h80, 8'h80, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        a = 8'hAA;
        b = 8'h55;
        chk("op8080_hold", {22'd0, ovf, cout, sum}, {22'd0, 1'b1, 1'b1, 8'h01});

        // Start held through DONE with operands changed mid-RUN.
        issue(8'h5A, 8'h33, 1'b0, 1'b1);
        a   = 8'h11;
        b   = 8'h22;
        cin = 1'b0;
        finish_op("b2b_first", 8'h5A, 8'h33, 1'b0);
        tick();
        chk("b2b_gap", {29'd0, ready, busy, done}, 32'b100);
        tick();
        start = 1'b0;
        chk("b2b_accept", {29'd0, ready, busy, done}, 32'b010);
        finish_op("b2b_second", 8'h11, 8'h22, 1'b0);
        chk("b2b_lit", 32'(sum), 32'h33);
        tick();

        // Reset four cycles into RUN.
        issue(8'h7F, 8'h01, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_flags", {29'd0, ready, busy, done}, 32'b100);
        chk("abort_outs",  {22'd0, ovf, cout, sum}, 32'd0);
        for (int i = 0; i < WIDTH; i++) begin
            tick();
            chk("abort_nodone", 32'(done), 32'd0);
        end
        issue(8'h01, 8'h01, 1'b0, 1'b0);
        finish_op("post_abort", 8'h01, 8'h01, 1'b0);
        chk("post_abort_lit", 32'(sum), 32'h02);
        tick();

        for (int n = 0; n < 24; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            rk = 1'($urandom);
            issue(ra, rb, rc, rk);
            a  = WIDTH'($urandom);
            b  = WIDTH'($urandom);
            finish_op("rand", ra, rb, rc);
            e  = ref_add(ra, rb, rc);
            start = 1'b0;
            tick();
            chk("rand_idle", {29'd0, ready, busy, done}, 32'b100);
            chk("rand_held", {22'd0, ovf, cout, sum}, 32'(e));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
